// File: rtl/scancode_pkg.sv
// Shared definitions for the PS/2 scancode sequencer: prefix bytes, the list of
// bytes dropped as keyboard status/replies, the parser state encoding and the
// 9-bit queue entry layout.
package scancode_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;

    // Keyboard status and command replies; these never carry key information.
    localparam int         NUM_DISCARD = 7;
    localparam logic [7:0] DISCARD_BYTES [NUM_DISCARD] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
    };

    localparam int GAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } parse_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } entry_t;

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (b == DISCARD_BYTES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/scancode_fifo.sv
// Synchronous FIFO of {ext,code} make entries. The head is visible on rdata_o
// without a pop, and a push into a full FIFO is accepted when a pop happens in
// the same cycle.
module scancode_fifo
    import scancode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit distinguishes full from empty when the addresses match.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    entry_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; these define occupancy so they are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; empty pointers already make its
    // contents unobservable, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/scancode_sequencer.sv
// Turns the raw PS/2 byte stream into rate-limited make-code strobes: parses
// E0/F0 prefixes, drops status bytes and typematic repeats, queues makes and
// issues them at most once per GAP_CYCLES+1 cycles.
module scancode_sequencer
    import scancode_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clr_overflow,
    output logic [7:0] scancode,
    output logic       flag,
    output logic       extended,
    output logic       overflow,
    output logic       busy
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    parse_state_e     state_q, state_d;
    entry_t           held_q;
    logic             held_valid_q;
    logic [GAP_W-1:0] gap_q;
    logic             flag_q;
    logic [7:0]       scancode_q;
    logic             extended_q;
    logic             overflow_q;

    logic             is_make;
    logic             is_break;
    logic             byte_ext;
    entry_t           rx_entry;
    logic             matches_held;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             pop;
    entry_t           fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    // Classify the incoming byte in the context of the current prefix state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        byte_ext = 1'b0;
        if (rx_valid) begin
            if (is_discard(rx_data)) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == PREFIX_EXT)        state_d = ST_GOT_E0;
                        else if (rx_data == PREFIX_BREAK) state_d = ST_GOT_F0;
                        else                              is_make = 1'b1;
                    end
                    ST_GOT_E0: begin
                        if (rx_data == PREFIX_BREAK) begin
                            state_d = ST_GOT_E0F0;
                        end else begin
                            is_make  = 1'b1;
                            byte_ext = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_GOT_F0: begin
                        is_break = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    ST_GOT_E0F0: begin
                        is_break = 1'b1;
                        byte_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign rx_entry     = '{ext: byte_ext, code: rx_data};
    assign matches_held = held_valid_q && (held_q == rx_entry);
    assign pop          = !fifo_empty && (gap_q == '0);
    assign push_req     = is_make && !matches_held;
    assign push_ok      = push_req && (!fifo_full || pop);
    assign drop         = push_req && fifo_full && !pop;

    scancode_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (vga_clk),
        .rst_n   (reset),
        .push_i  (push_ok),
        .wdata_i (rx_entry),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Prefix parser state register.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Typematic filter: remember the last queued make until its own break arrives.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            held_q       <= '0;
            held_valid_q <= 1'b0;
        end else if (push_ok) begin
            held_q       <= rx_entry;
            held_valid_q <= 1'b1;
        end else if (is_break && matches_held) begin
            held_valid_q <= 1'b0;
        end
    end

    // Issue path: pop the head into the output registers and start the gap.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            flag_q     <= 1'b0;
            scancode_q <= 8'h00;
            extended_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            flag_q <= pop;
            if (pop) begin
                scancode_q <= fifo_head.code;
                extended_q <= fifo_head.ext;
                gap_q      <= GAP_LOAD;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset)            overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (clr_overflow) overflow_q <= 1'b0;
    end

    assign scancode = scancode_q;
    assign flag     = flag_q;
    assign extended = extended_q;
    assign overflow = overflow_q;
    assign busy     = !fifo_empty || (gap_q != '0);

endmodule

// File: tb/tb_scancode_sequencer.sv
// Self-checking bench for scancode_sequencer. Expected {ext,code} entries are
// queued when a make is sent and popped by a monitor whenever flag is seen.
// The DUT runs with a 2-deep FIFO so the overflow scenarios actually fill it.
module tb_scancode_sequencer;

    logic       vga_clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clr_overflow;
    logic [7:0] scancode;
    logic       flag;
    logic       extended;
    logic       overflow;
    logic       busy;

    logic [8:0] exp_q [$];
    logic [8:0] exp_w;
    logic       prev_flag;
    int         vectors;
    int         miscompares;
    int         flags_seen;

    scancode_sequencer #(
        .FIFO_DEPTH (2),
        .GAP_CYCLES (2)
    ) dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .clr_overflow (clr_overflow),
        .scancode     (scancode),
        .flag         (flag),
        .extended     (extended),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: every flag must match the oldest expected entry.
    initial prev_flag = 1'b0;
    always @(negedge vga_clk) begin
        if (reset === 1'b1 && flag === 1'b1) begin
            flags_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_flag: got ext=%0b code=%h, required no flag",
                         extended, scancode);
            end else begin
                exp_w = exp_q.pop_front();
                if ({extended, scancode} !== exp_w) begin
                    miscompares++;
                    $display("FAIL flag_data: got ext=%0b code=%h, required ext=%0b code=%h",
                             extended, scancode, exp_w[8], exp_w[7:0]);
                end
            end
            vectors++;
            if (prev_flag !== 1'b0) begin
                miscompares++;
                $display("FAIL flag_spacing: got flag in consecutive cycles, required gap of 2");
            end
        end
        prev_flag = flag;
    end

    // Drive one byte for exactly one cycle; entered and left at posedge+1.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge vga_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic expect_make(input logic ext, input logic [7:0] code);
        exp_q.push_back({ext, code});
    endtask

    task automatic do_reset;
        reset        = 1'b0;
        rx_valid     = 1'b0;
        clr_overflow = 1'b0;
        @(posedge vga_clk);
        #1;
        reset = 1'b1;
    endtask

    // Wait until the DUT is idle and every expected flag was seen.
    task automatic drain(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge vga_clk);
            if (busy === 1'b0 && exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1;
        vectors++;
        if ({flag, scancode, extended, overflow, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_values: got flag=%b code=%h ext=%b ovf=%b busy=%b, required all 0",
                     flag, scancode, extended, overflow, busy);
        end
        reset = 1'b1;
        @(negedge vga_clk);
        vectors++;
        if (flag !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got flag=%b busy=%b, required 0 0", flag, busy);
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_latency;
        do_reset();
        expect_make(1'b0, 8'h2B);
        put(8'h2B);
        @(negedge vga_clk);
        vectors++;
        if (flag !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_t1: got flag=%b busy=%b, required flag=0 busy=1", flag, busy);
        end
        @(negedge vga_clk);
        vectors++;
        if (flag !== 1'b1 || scancode !== 8'h2B || extended !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_t2: got flag=%b code=%h ext=%b, required 1 2b 0",
                     flag, scancode, extended);
        end
        @(negedge vga_clk);
        vectors++;
        if (busy !== 1'b1 || flag !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_busy: got busy=%b flag=%b, required busy=1 flag=0", busy, flag);
        end
        @(negedge vga_clk);
        vectors++;
        if (busy !== 1'b0 || scancode !== 8'h2B) begin
            miscompares++;
            $display("FAIL busy_fall_hold: got busy=%b code=%h, required busy=0 code=2b",
                     busy, scancode);
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_typematic;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        expect_make(1'b0, 8'h2B);
        expect_make(1'b0, 8'h2B);
        put(8'h2B); put(8'h2B); put(8'h2B);
        put(8'hF0); put(8'h2B);
        put(8'h2B);
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 2) begin
            miscompares++;
            $display("FAIL typematic: got %0d flags (timeout=%0b), required 2", flags_seen - f0, to);
        end
    endtask

    task automatic test_extended;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        expect_make(1'b1, 8'h75);
        put(8'hE0); put(8'h75);
        put(8'hE0); put(8'hF0); put(8'h75);
        // Held was cleared by the E0-break, so the key registers again.
        expect_make(1'b1, 8'h75);
        put(8'hE0); put(8'h75);
        // A plain break of the same code does not clear the extended hold.
        put(8'hF0); put(8'h75);
        put(8'hE0); put(8'h75);
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 2) begin
            miscompares++;
            $display("FAIL extended: got %0d flags (timeout=%0b), required 2", flags_seen - f0, to);
        end
    endtask

    task automatic test_discard;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        put(8'hAA); put(8'hFA);
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL discard_only: got %0d flags busy=%b, required 0 flags busy=0",
                     flags_seen - f0, busy);
        end
        expect_make(1'b0, 8'h2B);
        put(8'hE0); put(8'hFA); put(8'h2B);
        expect_make(1'b0, 8'h1C);
        put(8'hF0); put(8'hFE); put(8'h1C);
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 2) begin
            miscompares++;
            $display("FAIL discard_prefix: got %0d flags (timeout=%0b), required 2",
                     flags_seen - f0, to);
        end
    endtask

    task automatic test_overflow;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        // 2D arrives while full with no pop and is dropped; 34 lands on a pop
        // cycle and is kept; 32 arrives while full again and is dropped.
        expect_make(1'b0, 8'h15);
        expect_make(1'b0, 8'h33);
        expect_make(1'b0, 8'h22);
        expect_make(1'b0, 8'h34);
        put(8'h15); put(8'h33); put(8'h22);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_early: got %b, required 0", overflow);
        end
        put(8'h2D); put(8'h34); put(8'h32);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 4 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drain: got %0d flags ovf=%b, required 4 flags ovf=1",
                     flags_seen - f0, overflow);
        end
        clr_overflow = 1'b1;
        @(posedge vga_clk);
        #1;
        clr_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_overflow_priority;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        expect_make(1'b0, 8'h11);
        expect_make(1'b0, 8'h12);
        expect_make(1'b0, 8'h13);
        put(8'h11); put(8'h12); put(8'h13);
        clr_overflow = 1'b1;
        put(8'h14);
        clr_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_priority: got %b, required 1", overflow);
        end
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 3) begin
            miscompares++;
            $display("FAIL overflow_priority_flags: got %0d, required 3", flags_seen - f0);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int f0;
        do_reset();
        f0 = flags_seen;
        expect_make(1'b0, 8'h1C);
        put(8'h1C); put(8'h1B); put(8'h1D); put(8'hE0);
        // 1B and 1D are still queued and the parser holds an E0 prefix.
        reset = 1'b0;
        #2;
        vectors++;
        if ({flag, scancode, extended, overflow, busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset: got flag=%b code=%h ext=%b ovf=%b busy=%b, required all 0",
                     flag, scancode, extended, overflow, busy);
        end
        @(posedge vga_clk);
        #1;
        reset = 1'b1;
        repeat (8) @(negedge vga_clk);
        vectors++;
        if ((flags_seen - f0) != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_flush: got %0d flags pending=%0d, required 1 flag pending=0",
                     flags_seen - f0, exp_q.size());
        end
        @(posedge vga_clk);
        #1;
        expect_make(1'b0, 8'h23);
        put(8'h23);
        drain(to);
        vectors++;
        if (to || (flags_seen - f0) != 2) begin
            miscompares++;
            $display("FAIL reset_resume: got %0d flags, required 2", flags_seen - f0);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        flags_seen   = 0;
        test_reset();
        test_latency();
        test_typematic();
        test_extended();
        test_discard();
        test_overflow();
        test_overflow_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scancode_sequencer.md
SCANCODE_SEQUENCER -- requirements
Module: scancode_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered make-code entries (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum number of idle cycles between consecutive flag pulses (0..255).
REQ-003 SHALL have port vga_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-007 SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.
REQ-008 SHALL have port scancode, output, 8 bits: make code presented to the decoder.
REQ-009 SHALL have port flag, output, 1 bit: one-cycle strobe qualifying scancode and extended.
REQ-010 SHALL have port extended, output, 1 bit: high when the issued code was E0-prefixed.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a make code is dropped because the FIFO is full.
REQ-012 SHALL have port busy, output, 1 bit: high while the FIFO is non-empty or the gap counter is non-zero.

Function
REQ-013 Parser FSM SHALL have states IDLE, GOT_E0, GOT_F0, GOT_E0F0, and SHALL advance only in cycles where rx_valid=1.
REQ-014 IDLE transitions: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; any other byte is handled as a make code with ext=0 and the FSM stays in IDLE.
REQ-015 GOT_E0 transitions: 0xF0 -> GOT_E0F0; any other byte is a make code with ext=1 -> IDLE.
REQ-016 GOT_F0 and GOT_E0F0: the byte is a break code with ext=0 or ext=1 respectively -> IDLE; break codes SHALL never be pushed.
REQ-017 Bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF received in any state SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-018 Typematic suppression: a 9-bit held register {ext,code} SHALL record the last pushed make; a make equal to held SHALL NOT be pushed.
REQ-019 A break whose {ext,code} equals held SHALL clear held to invalid; a non-matching break SHALL leave held unchanged.
REQ-020 An accepted make SHALL be written as a 9-bit entry {ext,code} into the FIFO in the same cycle as its rx_valid.
REQ-021 Issue rule: when the FIFO is non-empty and the gap counter is 0, the head SHALL be popped and registered onto scancode/extended, with flag=1 for exactly one cycle.
REQ-022 Latency: a make accepted in cycle t with an empty FIFO and gap=0 SHALL produce flag=1 in cycle t+2.
REQ-023 The gap counter SHALL load GAP_CYCLES in the cycle flag=1 and decrement to 0; with GAP_CYCLES=0, flags MAY occur in back-to-back cycles.
REQ-024 scancode and extended SHALL hold their last issued value while flag=0.
REQ-025 FIFO full with a push and no pop: the entry SHALL be dropped, held SHALL NOT update, and overflow SHALL be set.
REQ-026 FIFO full with a push and a pop in the same cycle: the push SHALL be accepted, with no overflow.
REQ-027 clr_overflow=1 SHALL clear overflow next cycle; a simultaneous new overflow event SHALL take priority (overflow stays 1).

Reset
REQ-028 reset=0 SHALL asynchronously force: FSM=IDLE; FIFO empty; held invalid; gap=0; flag=0; scancode=0x00; extended=0; overflow=0; busy=0.
REQ-029 Reset mid-sequence (e.g. after 0xE0) SHALL discard the partial prefix and all buffered entries; no flag SHALL be produced after deassertion until a new make code arrives.

Structure
REQ-030 Prefix codes (0xE0, 0xF0), the discard-byte list, and the FSM state encoding SHALL live in a shared package, scancode_pkg.
REQ-031 The FIFO SHALL be a separate sub-module, scancode_fifo (synchronous, 9-bit wide, FIFO_DEPTH deep, with full/empty outputs).

Verification
REQ-032 rx 0x2B at t -> flag=1 at t+2 with scancode=0x2B, extended=0; busy falls after GAP_CYCLES more cycles.
REQ-033 rx 0x2B, 0x2B, 0x2B, then F0, 2B, then 0x2B -> exactly two flags, both 0x2B.
REQ-034 rx E0, 0x75, then E0, F0, 0x75 -> one flag with scancode=0x75, extended=1; no flag for the break.
REQ-035 Six distinct makes (0x15, 0x33, 0x22, 0x2D, 0x34, 0x32) on consecutive cycles with GAP_CYCLES=2 -> overflow=1; the flag sequence is an in-order prefix; clr_overflow clears overflow.
REQ-036 rx 0xAA and 0xFA -> no flag; rx E0, then 0xFA, then 0x2B -> flag with 0x2B, extended=0.
REQ-037 Assert reset after E0 with two entries queued -> all outputs at reset values; after release, rx 0x23 -> single flag with 0x23, extended=0.
